// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake and feeds one instruction per delivery to the IF/ID buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_if,
  output logic [31:0] pc_if,
  output logic        halted_controller_if,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_reg, hold_reg_n;
  logic        squash, squash_n;
  logic [31:0] inst_n, pc_if_n;
  logic        halted_n;
  logic        deliver;
  logic [31:0] deliver_data;

  assign imem_req   = (state == REQ) && !redirect_valid;
  assign imem_addr  = pc;
  assign fetch_busy = (state == WAIT) || (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state                <= REQ;
      pc                   <= RESET_PC;
      hold_reg             <= 32'h0;
      squash               <= 1'b0;
      inst_if              <= NOP_INST;
      pc_if                <= RESET_PC;
      halted_controller_if <= 1'b0;
    end else begin
      state                <= state_n;
      pc                   <= pc_n;
      hold_reg             <= hold_reg_n;
      squash               <= squash_n;
      inst_if              <= inst_n;
      pc_if                <= pc_if_n;
      halted_controller_if <= halted_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_reg_n   = hold_reg;
    squash_n     = squash;
    deliver      = 1'b0;
    deliver_data = imem_rdata;

    case (state)
      REQ: begin
        if (redirect_valid) pc_n = redirect_pc;
        else                state_n = WAIT;
      end
      WAIT: begin
        if (imem_ready) begin
          // A squashed or concurrently-redirected response is thrown away.
          if (squash || redirect_valid) begin
            squash_n = 1'b0;
            if (redirect_valid) pc_n = redirect_pc;
            state_n = REQ;
          end else if (!stall) begin
            deliver = 1'b1;
          end else begin
            hold_reg_n = imem_rdata;
            state_n    = HOLD;
          end
        end else if (redirect_valid) begin
          squash_n = 1'b1;
          pc_n     = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = REQ;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_data = hold_reg;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase

    if (deliver) begin
      pc_n    = pc + 32'd4;
      state_n = (deliver_data == HALT_INST) ? HALT : REQ;
    end

    // Output register: flush beats delivery, delivery beats bubble, stall freezes.
    inst_n   = inst_if;
    pc_if_n  = pc_if;
    halted_n = halted_controller_if;
    if (redirect_valid) begin
      inst_n   = NOP_INST;
      halted_n = 1'b0;
    end else if (deliver) begin
      inst_n   = deliver_data;
      pc_if_n  = pc;
      halted_n = (deliver_data == HALT_INST);
    end else if (!stall) begin
      inst_n   = NOP_INST;
      halted_n = 1'b0;
    end
  end

endmodule
